// File: rtl/ram_program_loader_if.sv
// Byte-stream handshake carrying program frames into ram_program_loader.
// The master drives bytes and the loader, as slave, returns in_ready.
interface ram_program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ram_program_loader.sv
// Frame parser (sync, addr, len, data, checksum) that writes the Neander 32-byte RAM
// and holds the CPU in reset until a frame arrives with a matching checksum.
module ram_program_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_program_loader_if.slave  in_bus,
    output logic                 mem_load_en,
    output logic [4:0]           mem_load_addr,
    output logic [7:0]           mem_load_data,
    output logic                 cpu_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHECK, S_RUN, S_ERR
    } state_t;

    state_t     state;
    logic [4:0] ptr;
    logic [5:0] remaining;
    logic [7:0] sum;
    logic       accept;
    logic       is_sync;

    // The loader never stalls.
    assign in_bus.in_ready = 1'b1;
    assign accept  = in_bus.in_valid;
    assign is_sync = (in_bus.in_data == SYNC_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ptr           <= '0;
            remaining     <= '0;
            sum           <= '0;
            mem_load_en   <= 1'b0;
            mem_load_addr <= '0;
            mem_load_data <= '0;
            cpu_rst_n     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            mem_load_en <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_RUN, S_ERR: begin
                        if (is_sync) begin
                            state     <= S_ADDR;
                            cpu_rst_n <= 1'b0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            error     <= 1'b0;
                        end
                    end
                    S_ADDR: begin
                        if (in_bus.in_data[7:5] != 3'b000) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            ptr   <= in_bus.in_data[4:0];
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (in_bus.in_data == 8'd0 || in_bus.in_data > 8'd32) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            remaining <= in_bus.in_data[5:0];
                            sum       <= '0;
                            state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        mem_load_en   <= 1'b1;
                        mem_load_addr <= ptr;
                        mem_load_data <= in_bus.in_data;
                        sum           <= sum + in_bus.in_data;
                        ptr           <= ptr + 5'd1;
                        remaining     <= remaining - 6'd1;
                        if (remaining == 6'd1)
                            state <= S_CHECK;
                    end
                    S_CHECK: begin
                        busy <= 1'b0;
                        if (8'(sum + in_bus.in_data) == 8'd0) begin
                            state     <= S_RUN;
                            cpu_rst_n <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader: frames in, RAM writes and status out.
module tb_ram_program_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       mem_load_en;
    logic [4:0] mem_load_addr;
    logic [7:0] mem_load_data;
    logic       cpu_rst_n, busy, done, error;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned wr_count = 0;
    logic [7:0]  ram_img [32];

    ram_program_loader_if bus();

    ram_program_loader #(.SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_bus        (bus.slave),
        .mem_load_en   (mem_load_en),
        .mem_load_addr (mem_load_addr),
        .mem_load_data (mem_load_data),
        .cpu_rst_n     (cpu_rst_n),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Behaves as the external RAM: captures each strobed write on the next edge.
    always @(posedge clk) begin
        if (mem_load_en) begin
            ram_img[mem_load_addr] = mem_load_data;
            wr_count++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic idle_cycles(input int unsigned n);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hA5;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        bus.in_data = 8'h00;
    endtask

    task automatic test_reset;
        logic [18:0] got;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        got = {bus.in_ready, mem_load_en, mem_load_addr, mem_load_data, cpu_rst_n, busy, done, error};
        vectors++;
        if (got !== 19'b1_0_00000_00000000_0_0_0_0) begin
            miscompares++;
            $display("FAIL reset_values: got %b want %b", got, 19'b1_0_00000_00000000_0_0_0_0);
        end
        rst = 1'b0;
        idle_cycles(2);
        vectors++;
        if ({busy, cpu_rst_n} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_gap: got busy/cpu_rst_n %b want 00", {busy, cpu_rst_n});
        end
    endtask

    task automatic test_basic;
        logic [7:0] dat [3];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        send_byte(8'h42);
        send_byte(8'hA5);
        vectors++;
        if ({busy, cpu_rst_n} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_sync: got busy/cpu_rst_n %b want 10", {busy, cpu_rst_n});
        end
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            send_byte(dat[i]);
            vectors++;
            if ({mem_load_en, mem_load_addr, mem_load_data} !== {1'b1, 5'(i), dat[i]}) begin
                miscompares++;
                $display("FAIL basic_write%0d: got en=%b a=%h d=%h want en=1 a=%h d=%h",
                         i, mem_load_en, mem_load_addr, mem_load_data, 5'(i), dat[i]);
            end
        end
        // 11+22+33 = 66, so 9A closes the sum to zero.
        send_byte(8'h9A);
        vectors++;
        if ({mem_load_en, cpu_rst_n, done, error, busy} !== 5'b01100) begin
            miscompares++;
            $display("FAIL basic_run: got en/rst_n/done/err/busy %b want 01100",
                     {mem_load_en, cpu_rst_n, done, error, busy});
        end
        vectors++;
        if ({mem_load_addr, mem_load_data} !== {5'd2, 8'h33}) begin
            miscompares++;
            $display("FAIL basic_hold: got a=%h d=%h want a=02 d=33", mem_load_addr, mem_load_data);
        end
    endtask

    task automatic test_wrap;
        logic [4:0] exp_a [4];
        exp_a[0] = 5'h1E; exp_a[1] = 5'h1F; exp_a[2] = 5'h00; exp_a[3] = 5'h01;
        send_byte(8'hA5);
        send_byte(8'h1E);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(i + 1));
            vectors++;
            if ({mem_load_en, mem_load_addr, mem_load_data} !== {1'b1, exp_a[i], 8'(i + 1)}) begin
                miscompares++;
                $display("FAIL wrap_write%0d: got en=%b a=%h d=%h want en=1 a=%h d=%h",
                         i, mem_load_en, mem_load_addr, mem_load_data, exp_a[i], 8'(i + 1));
            end
        end
        send_byte(8'hF6);
        vectors++;
        if ({cpu_rst_n, done, error} !== 3'b110) begin
            miscompares++;
            $display("FAIL wrap_done: got rst_n/done/err %b want 110", {cpu_rst_n, done, error});
        end
    endtask

    task automatic test_bad_checksum;
        int unsigned w0;
        w0 = wr_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h00);
        vectors++;
        if ({cpu_rst_n, done, error, busy} !== 4'b0010) begin
            miscompares++;
            $display("FAIL badsum_err: got rst_n/done/err/busy %b want 0010", {cpu_rst_n, done, error, busy});
        end
        vectors++;
        if (wr_count - w0 !== 2 || ram_img[0] !== 8'h10 || ram_img[1] !== 8'h20) begin
            miscompares++;
            $display("FAIL badsum_writes: got count=%0d ram0=%h ram1=%h want 2 10 20",
                     wr_count - w0, ram_img[0], ram_img[1]);
        end
        send_byte(8'hA5);
        vectors++;
        if ({error, done, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL badsum_clear: got err/done/busy %b want 001", {error, done, busy});
        end
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h01);
        vectors++;
        if ({cpu_rst_n, done, error} !== 3'b110) begin
            miscompares++;
            $display("FAIL badsum_recover: got rst_n/done/err %b want 110", {cpu_rst_n, done, error});
        end
    endtask

    task automatic test_format_errors;
        logic [7:0] frm [3][3];
        int unsigned w0;
        frm[0][0] = 8'hA5; frm[0][1] = 8'h00; frm[0][2] = 8'h00;
        frm[1][0] = 8'hA5; frm[1][1] = 8'h00; frm[1][2] = 8'h21;
        frm[2][0] = 8'hA5; frm[2][1] = 8'h20; frm[2][2] = 8'h01;
        for (int f = 0; f < 3; f++) begin
            w0 = wr_count;
            for (int j = 0; j < 3; j++) send_byte(frm[f][j]);
            idle_cycles(1);
            vectors++;
            if ({cpu_rst_n, done, error, busy} !== 4'b0010 || wr_count != w0) begin
                miscompares++;
                $display("FAIL format_err%0d: got rst_n/done/err/busy %b writes=%0d want 0010 writes=0",
                         f, {cpu_rst_n, done, error, busy}, wr_count - w0);
            end
        end
    endtask

    task automatic test_run_and_async_reset;
        logic [18:0] got;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h7E);
        vectors++;
        if ({cpu_rst_n, done, busy} !== 3'b110) begin
            miscompares++;
            $display("FAIL run_ignore: got rst_n/done/busy %b want 110", {cpu_rst_n, done, busy});
        end
        send_byte(8'hA5);
        vectors++;
        if ({cpu_rst_n, done, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL run_resync: got rst_n/done/busy %b want 001", {cpu_rst_n, done, busy});
        end
        send_byte(8'h04);
        send_byte(8'h04);
        send_byte(8'h5A);
        vectors++;
        if ({mem_load_en, mem_load_addr, mem_load_data} !== {1'b1, 5'd4, 8'h5A}) begin
            miscompares++;
            $display("FAIL mid_write: got en=%b a=%h d=%h want en=1 a=04 d=5a",
                     mem_load_en, mem_load_addr, mem_load_data);
        end
        rst = 1'b1;
        #1;
        got = {bus.in_ready, mem_load_en, mem_load_addr, mem_load_data, cpu_rst_n, busy, done, error};
        vectors++;
        if (got !== 19'b1_0_00000_00000000_0_0_0_0) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", got, 19'b1_0_00000_00000000_0_0_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Continuing the aborted frame must not resume it: loader is back in IDLE.
        send_byte(8'h5B);
        vectors++;
        if ({mem_load_en, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_idle: got en/busy %b want 00", {mem_load_en, busy});
        end
    endtask

    task automatic test_gapped_full_frame;
        logic [7:0]  img [32];
        logic [7:0]  s;
        int unsigned w0;
        int unsigned bad;
        s = 8'h00;
        for (int i = 0; i < 32; i++) begin
            img[i] = 8'(i * 7 + 3);
            s = s + img[i];
        end
        for (int i = 0; i < 32; i++) ram_img[i] = 8'h00;
        w0 = wr_count;
        send_byte(8'hA5);
        idle_cycles($urandom_range(0, 3));
        send_byte(8'h05);
        idle_cycles($urandom_range(0, 3));
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            idle_cycles($urandom_range(0, 2));
            send_byte(img[i]);
        end
        idle_cycles($urandom_range(0, 3));
        send_byte(8'(-s));
        vectors++;
        if ({cpu_rst_n, done, error} !== 3'b110) begin
            miscompares++;
            $display("FAIL gap_done: got rst_n/done/err %b want 110", {cpu_rst_n, done, error});
        end
        vectors++;
        if (wr_count - w0 != 32) begin
            miscompares++;
            $display("FAIL gap_pulses: got %0d want 32", wr_count - w0);
        end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (ram_img[(i + 5) % 32] !== img[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL gap_image: got %0d wrong bytes want 0", bad);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset;
        test_basic;
        test_wrap;
        test_bad_checksum;
        test_format_errors;
        test_run_and_async_reset;
        test_gapped_full_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
